param_register_file: RTL and testbench



---
 rtl/param_register_file_pkg.sv | 13 +
 rtl/param_register_file_rf_ram.sv | 26 ++
 rtl/param_register_file.sv | 124 ++++++++++++
 tb/tb_param_register_file.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/param_register_file_pkg.sv
// Shared CPU register-file package: default widths and the
// clear/run state encoding used by param_register_file.
package param_register_file_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/param_register_file_rf_ram.sv
// rf_ram: synchronous array, one write port, two registered
// read ports (old contents on same-address write), no reset.
// Ports: CLK, we/waddr/wdata write, raddr_a/raddr_b -> rdata_a/rdata_b.
module rf_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/param_register_file.sv
// param_register_file: 2R/1W register file with post-reset clear sweep,
// optional hardwired r0 (ZERO_REG0) and optional write-to-read
// forwarding (define RF_BYPASS_EN).
// Ports: CLK, reset (sync, active-high), RFwrite/regW/dataW write,
// regA/regB -> dataA/dataB (1-cycle latency), ready after sweep.
module param_register_file
    import param_register_file_pkg::*;
#(
    parameter int DATA_W    = RF_DATA_W,
    parameter int ADDR_W    = RF_ADDR_W,
    parameter int ZERO_REG0 = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RFwrite,
    input  logic [ADDR_W-1:0] regA,
    input  logic [ADDR_W-1:0] regB,
    input  logic [ADDR_W-1:0] regW,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB,
    output logic              ready
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam bit ZR0 = (ZERO_REG0 != 0);
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              ready_d;

    // Output select flags, registered alongside the RAM read so the
    // final mux is driven by flops only.
    logic              zero_a_q, zero_a_d;
    logic              zero_b_q, zero_b_d;
    logic              byp_a_q, byp_a_d;
    logic              byp_b_q, byp_b_d;
    logic [DATA_W-1:0] byp_data_q;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] ram_a, ram_b;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            ready     <= 1'b0;
            zero_a_q  <= 1'b1;
            zero_b_q  <= 1'b1;
            byp_a_q   <= 1'b0;
            byp_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            ready     <= ready_d;
            zero_a_q  <= zero_a_d;
            zero_b_q  <= zero_b_d;
            byp_a_q   <= byp_a_d;
            byp_b_q   <= byp_b_d;
        end
        byp_data_q <= dataW;
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        ready_d   = ready;
        zero_a_d  = 1'b1;
        zero_b_d  = 1'b1;
        byp_a_d   = 1'b0;
        byp_b_d   = 1'b0;
        we        = 1'b0;
        waddr     = regW;
        wdata     = dataW;
        if (!reset) begin
            unique case (state_q)
                CLEAR: begin
                    we        = 1'b1;
                    waddr     = clr_ptr_q;
                    wdata     = '0;
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    if (clr_ptr_q == LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
                RUN: begin
                    we       = RFwrite && !(ZR0 && regW == '0);
                    zero_a_d = ZR0 && regA == '0;
                    zero_b_d = ZR0 && regB == '0;
                    byp_a_d  = BYPASS && RFwrite && regW == regA;
                    byp_b_d  = BYPASS && RFwrite && regW == regB;
                end
            endcase
        end
    end

    rf_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLK     (CLK),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (regA),
        .raddr_b (regB),
        .rdata_a (ram_a),
        .rdata_b (ram_b)
    );

    // Zero wins over forwarding, forwarding over the array.
    assign dataA = zero_a_q ? '0 : (byp_a_q ? byp_data_q : ram_a);
    assign dataB = zero_b_q ? '0 : (byp_b_q ? byp_data_q : ram_b);

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: one default instance and
// one with ZERO_REG0=1 share the same stimulus.
module tb_param_register_file;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        RFwrite = 1'b0;
    logic [2:0]  regA = '0, regB = '0, regW = '0;
    logic [15:0] dataW = '0;
    logic [15:0] dataA0, dataB0, dataA1, dataB1;
    logic        ready0, ready1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG0(0)) dut0 (
        .CLK(CLK), .reset(reset), .RFwrite(RFwrite),
        .regA(regA), .regB(regB), .regW(regW), .dataW(dataW),
        .dataA(dataA0), .dataB(dataB0), .ready(ready0)
    );

    param_register_file #(.DATA_W(16), .ADDR_W(3), .ZERO_REG0(1)) dut1 (
        .CLK(CLK), .reset(reset), .RFwrite(RFwrite),
        .regA(regA), .regB(regB), .regW(regW), .dataW(dataW),
        .dataA(dataA1), .dataB(dataB1), .ready(ready1)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [2:0]  ra, rb, rw;
        logic [15:0] dw;
        logic [15:0] ea0, eb0, ea1, eb1;
        logic        er;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic we, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [2:0] rw,
                       input logic [15:0] dw, input logic [15:0] ea0,
                       input logic [15:0] eb0, input logic [15:0] ea1,
                       input logic [15:0] eb1, input logic er);
        vec_t v;
        v.rst = rst; v.we = we; v.ra = ra; v.rb = rb; v.rw = rw; v.dw = dw;
        v.ea0 = ea0; v.eb0 = eb0; v.ea1 = ea1; v.eb1 = eb1; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic read_all_zero(input string tag);
        RFwrite = 1'b0;
        for (int i = 0; i < 8; i++) begin
            regA = 3'(i);
            regB = 3'(7 - i);
            step();
            chk($sformatf("%s_d0A_r%0d", tag, i), dataA0, 16'h0);
            chk($sformatf("%s_d0B_r%0d", tag, 7 - i), dataB0, 16'h0);
            chk($sformatf("%s_d1A_r%0d", tag, i), dataA1, 16'h0);
            chk($sformatf("%s_d1B_r%0d", tag, 7 - i), dataB1, 16'h0);
        end
    endtask

    initial begin
        int n;
        logic [15:0] v;

        // reset edge, then 8 sweep edges with CLEAR-time writes to r2
        add(1, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 8; i++)
            add(0, (i == 1 || i == 5 || i == 8), 0, 0, 2, 16'hAAAA,
                0, 0, 0, 0, (i == 8));
        add(0, 0, 2, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
        add(0, 1, 1, 4, 3, 16'hBEEF, 0, 0, 0, 0, 1);
        add(0, 0, 3, 3, 0, 16'h0000, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 1);
        add(0, 1, 5, 6, 5, 16'h1234, BYP ? 16'h1234 : 16'h0, 0,
            BYP ? 16'h1234 : 16'h0, 0, 1);
        add(0, 0, 5, 5, 0, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1);
        add(0, 1, 0, 3, 0, 16'hFFFF, BYP ? 16'hFFFF : 16'h0, 16'hBEEF,
            0, 16'hBEEF, 1);
        add(0, 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 1);
        add(0, 1, 7, 2, 7, 16'h0F0F, BYP ? 16'h0F0F : 16'h0, 0,
            BYP ? 16'h0F0F : 16'h0, 0, 1);

        foreach (vecs[k]) begin
            reset   = vecs[k].rst;
            RFwrite = vecs[k].we;
            regA    = vecs[k].ra;
            regB    = vecs[k].rb;
            regW    = vecs[k].rw;
            dataW   = vecs[k].dw;
            step();
            chk($sformatf("v%0d_d0A", k), dataA0, vecs[k].ea0);
            chk($sformatf("v%0d_d0B", k), dataB0, vecs[k].eb0);
            chk($sformatf("v%0d_d1A", k), dataA1, vecs[k].ea1);
            chk($sformatf("v%0d_d1B", k), dataB1, vecs[k].eb1);
            chk($sformatf("v%0d_rdy0", k), 16'(ready0), 16'(vecs[k].er));
            chk($sformatf("v%0d_rdy1", k), 16'(ready1), 16'(vecs[k].er));
        end

        // fill r1..r7 and read back
        for (int i = 1; i < 8; i++) begin
            RFwrite = 1'b1;
            regW    = 3'(i);
            dataW   = 16'(i * 16'h1111);
            step();
        end
        RFwrite = 1'b0;
        for (int i = 1; i < 8; i++) begin
            regA = 3'(i);
            regB = 3'(i);
            step();
            v = 16'(i * 16'h1111);
            chk($sformatf("fill_d0A_r%0d", i), dataA0, v);
            chk($sformatf("fill_d1B_r%0d", i), dataB1, v);
        end

        // second reset, then reset again on the 4th sweep cycle
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            regA = 3'd1;
            regB = 3'd7;
            step();
            chk($sformatf("sweep_rdy_%0d", i), 16'(ready0), 16'h0);
            chk($sformatf("sweep_d0A_%0d", i), dataA0, 16'h0);
            chk($sformatf("sweep_d1B_%0d", i), dataB1, 16'h0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (ready0) begin
                n = i;
                break;
            end
            chk($sformatf("resweep_d0A_%0d", i), dataA0, 16'h0);
        end
        chk("resweep_ready_edges", 16'(n), 16'd8);
        chk("resweep_rdy1", 16'(ready1), 16'h1);
        read_all_zero("after_resweep");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
